// File: rtl/exec_cc_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_cc_stage
// Purpose  : Y86-64 execute back end: flag generation, condition-code
//            register, jXX/cmovXX condition evaluation and the E->M register.
// Revision : 1.0  initial release
// ============================================================================
module exec_cc_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] val_e,
    input  logic             hold,
    input  logic             cc_inhibit,
    output logic             e_cnd,
    output logic [2:0]       cc,
    output logic             m_valid,
    output logic [3:0]       m_icode,
    output logic [WIDTH-1:0] m_val_e,
    output logic             m_cnd
);

    localparam logic [3:0] c_ICODE_NOP   = 4'h1;
    localparam logic [3:0] c_ICODE_CMOV  = 4'h2;
    localparam logic [3:0] c_ICODE_OPQ   = 4'h6;
    localparam logic [3:0] c_ICODE_JXX   = 4'h7;
    localparam logic [3:0] c_FUN_ADD     = 4'h0;
    localparam logic [3:0] c_FUN_SUB     = 4'h1;
    localparam logic [2:0] c_CC_RESET    = 3'b100;

    logic             w_zf;
    logic             w_sf;
    logic             w_of;
    logic             w_a_s;
    logic             w_b_s;
    logic             w_set_cc;
    logic             w_lt;
    logic             w_cond;
    logic [2:0]       r_cc;
    logic             r_m_valid;
    logic [3:0]       r_m_icode;
    logic [WIDTH-1:0] r_m_val_e;
    logic             r_m_cnd;

    assign w_a_s = alu_a[WIDTH-1];
    assign w_b_s = alu_b[WIDTH-1];
    assign w_zf  = (val_e == '0);
    assign w_sf  = val_e[WIDTH-1];

    // Logical ops and undefined OPq encodings never report overflow.
    always_comb begin
        w_of = 1'b0;
        case (ifun)
            c_FUN_ADD: w_of = (w_a_s == w_b_s) & (w_sf != w_b_s);
            c_FUN_SUB: w_of = (w_a_s != w_b_s) & (w_sf != w_b_s);
            default:   w_of = 1'b0;
        endcase
    end

    assign w_set_cc = in_valid & (icode == c_ICODE_OPQ) & ~hold & ~cc_inhibit;

    // Conditions look at the committed register, not this cycle's flags.
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cond = 1'b0;
        case (ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = w_lt | r_cc[2];
            4'h2:    w_cond = w_lt;
            4'h3:    w_cond = r_cc[2];
            4'h4:    w_cond = ~r_cc[2];
            4'h5:    w_cond = ~w_lt;
            4'h6:    w_cond = ~w_lt & ~r_cc[2];
            default: w_cond = 1'b0;
        endcase
    end

    assign e_cnd = in_valid & ((icode == c_ICODE_CMOV) | (icode == c_ICODE_JXX)) & w_cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= c_CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    // A cycle without a real instruction advances as a nop bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_icode <= c_ICODE_NOP;
            r_m_val_e <= '0;
            r_m_cnd   <= 1'b0;
        end else if (!hold) begin
            r_m_valid <= in_valid;
            r_m_icode <= in_valid ? icode : c_ICODE_NOP;
            r_m_val_e <= in_valid ? val_e : '0;
            r_m_cnd   <= e_cnd;
        end
    end

    assign cc      = r_cc;
    assign m_valid = r_m_valid;
    assign m_icode = r_m_icode;
    assign m_val_e = r_m_val_e;
    assign m_cnd   = r_m_cnd;

endmodule
`default_nettype wire

// File: tb/tb_exec_cc_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_cc_stage
// Purpose  : Directed scenarios plus randomized run against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_exec_cc_stage;

    localparam int W = 64;
    localparam logic [W-1:0] c_MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] c_MINN = 64'h8000_0000_0000_0000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] val_e;
    logic         hold;
    logic         cc_inhibit;
    logic         e_cnd;
    logic [2:0]   cc;
    logic         m_valid;
    logic [3:0]   m_icode;
    logic [W-1:0] m_val_e;
    logic         m_cnd;

    int checks;
    int failures;

    // reference state
    logic [2:0]   exp_cc;
    logic         exp_mv;
    logic [3:0]   exp_mi;
    logic [W-1:0] exp_me;
    logic         exp_mc;

    exec_cc_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
        .alu_a(alu_a), .alu_b(alu_b), .val_e(val_e), .hold(hold),
        .cc_inhibit(cc_inhibit), .e_cnd(e_cnd), .cc(cc), .m_valid(m_valid),
        .m_icode(m_icode), .m_val_e(m_val_e), .m_cnd(m_cnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input logic h, input logic inh);
        in_valid = v; icode = ic; ifun = f; alu_a = a; alu_b = b; val_e = e;
        hold = h; cc_inhibit = inh;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags from exact signed arithmetic: overflow means the true result
    // does not fit in W signed bits.
    function automatic logic [2:0] ref_flags(input logic [3:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] e);
        logic signed [W+1:0] exact;
        logic signed [W+1:0] got;
        logic of;
        got = $signed({{2{e[W-1]}}, e});
        of  = 1'b0;
        if (f == 4'h0) begin
            exact = $signed({{2{b[W-1]}}, b}) + $signed({{2{a[W-1]}}, a});
            of = (exact != got);
        end else if (f == 4'h1) begin
            exact = $signed({{2{b[W-1]}}, b}) - $signed({{2{a[W-1]}}, a});
            of = (exact != got);
        end
        return {e == '0, $signed(e) < 0, of};
    endfunction

    function automatic logic ref_cond(input logic [3:0] f, input logic [2:0] c);
        logic zf, less;
        zf = c[2];
        less = c[1] != c[0];
        case (f)
            4'd0: return 1'b1;
            4'd1: return less || zf;
            4'd2: return less;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !less;
            4'd6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_ecnd();
        if (!in_valid) return 1'b0;
        if (icode != 4'd2 && icode != 4'd7) return 1'b0;
        return ref_cond(ifun, exp_cc);
    endfunction

    // Apply one clock edge to the reference state using the current inputs.
    task automatic model_edge();
        logic c;
        c = ref_ecnd();
        if (rst) begin
            exp_cc = 3'b100; exp_mv = 1'b0; exp_mi = 4'd1; exp_me = '0; exp_mc = 1'b0;
        end else if (!hold) begin
            if (in_valid && icode == 4'd6 && !cc_inhibit)
                exp_cc = ref_flags(ifun, alu_a, alu_b, val_e);
            exp_mv = in_valid;
            exp_mi = in_valid ? icode : 4'd1;
            exp_me = in_valid ? val_e : '0;
            exp_mc = c;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 4'd6, 4'd0, 64'd3, 64'd4, 64'd7, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cc, m_valid, m_icode, m_val_e, m_cnd} !== {3'b100, 1'b0, 4'd1, 64'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got cc=%b v=%b ic=%h ve=%h c=%b want cc=100 v=0 ic=1 ve=0 c=0",
                     cc, m_valid, m_icode, m_val_e, m_cnd);
        end
        drive(1'b1, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b1) begin
            failures++;
            $display("FAIL reset_je got e_cnd=%b want 1", e_cnd);
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'd6, 4'd0, c_MAXP, c_MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b0) begin
            failures++;
            $display("FAIL opq_ecnd got %b want 0", e_cnd);
        end
        tick();
        checks++;
        if ({cc, m_valid, m_icode, m_val_e} !== {3'b011, 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            failures++;
            $display("FAIL add_ovf got cc=%b v=%b ic=%h ve=%h want cc=011 v=1 ic=6 ve=fffffffffffffffe",
                     cc, m_valid, m_icode, m_val_e);
        end
        drive(1'b1, 4'd7, 4'd2, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b0) begin failures++; $display("FAIL add_jl got %b want 0", e_cnd); end
        drive(1'b1, 4'd7, 4'd1, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b0) begin failures++; $display("FAIL add_jle got %b want 0", e_cnd); end
        drive(1'b1, 4'd7, 4'd6, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b1) begin failures++; $display("FAIL add_jg got %b want 1", e_cnd); end
    endtask

    task automatic test_sub_zero();
        drive(1'b1, 4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({cc, m_valid, m_icode, m_val_e} !== {3'b100, 1'b1, 4'd6, 64'd0}) begin
            failures++;
            $display("FAIL sub_zero got cc=%b v=%b ic=%h ve=%h want cc=100 v=1 ic=6 ve=0",
                     cc, m_valid, m_icode, m_val_e);
        end
        drive(1'b1, 4'd7, 4'd4, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b0) begin failures++; $display("FAIL sub_jne got %b want 0", e_cnd); end
        drive(1'b1, 4'd7, 4'd3, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b1) begin failures++; $display("FAIL sub_je got %b want 1", e_cnd); end
    endtask

    task automatic test_xor_negative();
        drive(1'b1, 4'd6, 4'd3, 64'd0, c_MINN, c_MINN, 1'b0, 1'b0);
        tick();
        checks++;
        if (cc !== 3'b010) begin failures++; $display("FAIL xor_cc got %b want 010", cc); end
        drive(1'b1, 4'd7, 4'd2, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b1) begin failures++; $display("FAIL xor_jl got %b want 1", e_cnd); end
        drive(1'b1, 4'd2, 4'd5, 0, 0, 64'h55, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b0) begin failures++; $display("FAIL xor_cmovge got %b want 0", e_cnd); end
        tick();
        checks++;
        if ({m_valid, m_icode, m_val_e, m_cnd} !== {1'b1, 4'd2, 64'h55, 1'b0}) begin
            failures++;
            $display("FAIL cmov_reg got v=%b ic=%h ve=%h c=%b want v=1 ic=2 ve=55 c=0",
                     m_valid, m_icode, m_val_e, m_cnd);
        end
    endtask

    task automatic test_stall_inhibit();
        drive(1'b1, 4'd6, 4'd0, 64'd1, 64'd2, 64'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cc, m_valid, m_icode, m_val_e, m_cnd} !== {3'b010, 1'b1, 4'd2, 64'h55, 1'b0}) begin
                failures++;
                $display("FAIL hold_frozen[%0d] got cc=%b v=%b ic=%h ve=%h c=%b want cc=010 v=1 ic=2 ve=55 c=0",
                         i, cc, m_valid, m_icode, m_val_e, m_cnd);
            end
        end
        drive(1'b1, 4'd6, 4'd0, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
        tick();
        checks++;
        if ({cc, m_valid, m_icode, m_val_e} !== {3'b000, 1'b1, 4'd6, 64'd3}) begin
            failures++;
            $display("FAIL hold_release got cc=%b v=%b ic=%h ve=%h want cc=000 v=1 ic=6 ve=3",
                     cc, m_valid, m_icode, m_val_e);
        end
        drive(1'b1, 4'd6, 4'd1, 64'd9, 64'd9, 64'd0, 1'b0, 1'b1);
        tick();
        checks++;
        if ({cc, m_valid, m_icode, m_val_e} !== {3'b000, 1'b1, 4'd6, 64'd0}) begin
            failures++;
            $display("FAIL inhibit got cc=%b v=%b ic=%h ve=%h want cc=000 v=1 ic=6 ve=0",
                     cc, m_valid, m_icode, m_val_e);
        end
    endtask

    task automatic test_back_to_back();
        // cc is 000 here; the OPq sets ZF and the very next je must see it.
        drive(1'b1, 4'd6, 4'd1, 64'd7, 64'd7, 64'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd7, 4'd3, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b1) begin failures++; $display("FAIL b2b_je got %b want 1", e_cnd); end
    endtask

    task automatic test_bubble();
        drive(1'b0, 4'd7, 4'd0, 64'd1, 64'd2, 64'hDEAD, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b0) begin failures++; $display("FAIL bubble_ecnd got %b want 0", e_cnd); end
        tick();
        checks++;
        if ({m_valid, m_icode, m_val_e, m_cnd} !== {1'b0, 4'd1, 64'd0, 1'b0}) begin
            failures++;
            $display("FAIL bubble_reg got v=%b ic=%h ve=%h c=%b want v=0 ic=1 ve=0 c=0",
                     m_valid, m_icode, m_val_e, m_cnd);
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 4'd6, 4'd3, 64'd0, c_MINN, c_MINN, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd7, 4'd2, 0, 0, 64'h77, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cc, m_valid, m_icode, m_val_e, m_cnd} !== {3'b100, 1'b0, 4'd1, 64'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got cc=%b v=%b ic=%h ve=%h c=%b want cc=100 v=0 ic=1 ve=0 c=0",
                     cc, m_valid, m_icode, m_val_e, m_cnd);
        end
        drive(1'b1, 4'd7, 4'd3, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (e_cnd !== 1'b1) begin failures++; $display("FAIL mid_reset_je got %b want 1", e_cnd); end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return c_MAXP;
            2: return c_MINN;
            3: return '1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic test_random();
        logic [3:0]   ic, f;
        logic [W-1:0] a, b, e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cc = 3'b100; exp_mv = 1'b0; exp_mi = 4'd1; exp_me = '0; exp_mc = 1'b0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1: ic = 4'd6;
                2:    ic = 4'd7;
                3:    ic = 4'd2;
                4:    ic = 4'd1;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            a = rand_operand();
            b = rand_operand();
            case (f)
                4'd0: e = b + a;
                4'd1: e = b - a;
                4'd2: e = b & a;
                4'd3: e = b ^ a;
                default: e = {$urandom(), $urandom()};
            endcase
            drive($urandom_range(0, 7) != 0, ic, f, a, b, e,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (e_cnd !== ref_ecnd()) begin
                failures++;
                $display("FAIL rand_ecnd[%0d] got %b want %b (ic=%h f=%h cc=%b)",
                         n, e_cnd, ref_ecnd(), ic, f, exp_cc);
            end
            model_edge();
            tick();
            rst = 1'b0;
            checks++;
            if ({cc, m_valid, m_icode, m_val_e, m_cnd} !== {exp_cc, exp_mv, exp_mi, exp_me, exp_mc}) begin
                failures++;
                $display("FAIL rand_state[%0d] got cc=%b v=%b ic=%h ve=%h c=%b want cc=%b v=%b ic=%h ve=%h c=%b",
                         n, cc, m_valid, m_icode, m_val_e, m_cnd,
                         exp_cc, exp_mv, exp_mi, exp_me, exp_mc);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        drive(1'b0, 4'd1, 4'd0, 0, 0, 0, 1'b0, 1'b0);
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_xor_negative();
        test_stall_inhibit();
        test_back_to_back();
        test_bubble();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_cc_stage.md
# exec_cc_stage

Execute-stage back end of the Y86-64 datapath. It consumes the 64-bit result of the combinational ALU (add/sub/and/xor units) together with the operands and instruction fields. It derives the ZF/SF/OF flags and holds them in the architectural condition-code register. It evaluates the jXX/cmovXX condition and registers the result into the execute-to-memory pipeline register, with stall and CC-inhibit control.

## Interface
Parameters:
- WIDTH, 64, datapath width; flags and sign use bit WIDTH-1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  execute stage holds a real instruction this cycle
- icode  in  4  instruction code (2 = rrmovq/cmovXX, 6 = OPq, 7 = jXX, 1 = nop)
- ifun  in  4  function code (OPq: 0 add, 1 sub, 2 and, 3 xor; cond: 0..6)
- alu_a  in  WIDTH  ALU operand A (aluA)
- alu_b  in  WIDTH  ALU operand B (aluB); valE = B op A
- val_e  in  WIDTH  ALU result for this instruction
- hold  in  1  downstream stall; freeze CC and output register
- cc_inhibit  in  1  later stage has an exception; suppress CC update
- e_cnd  out  1  combinational condition result for the current instruction
- cc  out  3  {ZF, SF, OF} register contents
- m_valid  out  1  registered valid
- m_icode  out  4  registered icode
- m_val_e  out  WIDTH  registered val_e
- m_cnd  out  1  registered e_cnd

## Operation
- Flag generation is combinational from val_e.
  - ZF = (val_e == 0).
  - SF = val_e[WIDTH-1].
- OF by ifun, with s = sign bit of each operand and result:
  - add: OF = (a_s == b_s) & (val_e_s != b_s)
  - sub (val_e = b - a): OF = (a_s != b_s) & (val_e_s != b_s)
  - and, xor: OF = 0
- set_cc = in_valid & (icode == 6) & !hold & !cc_inhibit. When set_cc is high, cc loads {ZF,SF,OF} at the clock edge; otherwise cc holds.
- Condition evaluation uses the current cc register value, never the flags being computed this cycle:
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF) & !ZF
  - ifun 7..15: 0
- e_cnd equals the evaluated condition when in_valid and icode is 2 or 7; otherwise e_cnd = 0.
- Output register, when hold = 0:
  - m_valid <= in_valid
  - m_icode <= in_valid ? icode : 1 (bubble = nop)
  - m_val_e <= in_valid ? val_e : 0
  - m_cnd <= e_cnd
- When hold = 1, all m_* and cc retain their values. Inputs are assumed re-presented unchanged on the next cycle.
- ifun 4..15 with icode 6: flags are computed as for and/xor (OF = 0) and the CC update still occurs. Rejecting these encodings is handled upstream.

## Timing
- Reset (rst = 1 at an edge): cc = 3'b100 (ZF=1, SF=0, OF=0), m_valid = 0, m_icode = 4'h1, m_val_e = 0, m_cnd = 0.
- rst has priority over hold, cc_inhibit and all data inputs.
- Latency:
  - e_cnd: 0 cycles (combinational).
  - m_* outputs: 1 cycle.
  - cc: visible 1 cycle after the OPq is accepted.
- Back-to-back: an OPq in cycle N followed by jXX/cmovXX in cycle N+1 sees cc updated by the OPq. A jXX in the same cycle as an OPq sees the older cc.
- hold asserted while an OPq is present: no CC update that cycle. The update happens in the first cycle the OPq is present with hold = 0.
- cc_inhibit with OPq and hold = 0: cc unchanged, but the instruction still advances into m_* with its val_e.
- rst asserted mid-stream discards the in-flight instruction. The first post-reset cycle's jXX evaluates against ZF=1 (je taken).

## Test plan
- Reset: pulse rst with hold=1 and an OPq present. Require cc=100, m_valid=0, m_icode=1, m_val_e=0, and je (icode 7, ifun 3) giving e_cnd=1.
- Signed add overflow: OPq add with a=b=0x7FFF_FFFF_FFFF_FFFF, val_e=0xFFFF_FFFF_FFFF_FFFE. Next cycle require cc=010 plus OF=1, i.e. {0,1,1}; jl e_cnd=0, jle e_cnd=0, jg e_cnd=1.
- Subtract to zero: sub with a=b=5, val_e=0. Require cc=100; then jne e_cnd=0, je e_cnd=1, m_val_e=0 registered.
- xor result negative: a=0, b=0x8000_0000_0000_0000, val_e=b. Require cc=010; jl e_cnd=1 and cmovge (icode 2, ifun 5) e_cnd=0, m_cnd=0 next cycle.
- Stall and inhibit: OPq with hold=1 for 3 cycles, requiring cc and m_* frozen; hold drops and cc updates next edge. Repeat with cc_inhibit=1: cc unchanged, m_valid=1, m_icode=6.
- Bubble: in_valid=0 with icode=7, ifun=0. Require e_cnd=0, and next cycle m_valid=0, m_icode=1, m_val_e=0.
